// File: rtl/bram_pkg.sv
// Shared types and limits for the true dual-port block RAM.
package bram_pkg;

    // Same-port read-during-write result selection
    typedef enum logic {
        RDW_OLD = 1'b0,
        RDW_NEW = 1'b1
    } rdw_mode_t;

    // Initialisation sweep state
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } init_state_t;

    localparam int unsigned RD_LAT_MIN = 2;
    localparam int unsigned RD_LAT_MAX = 4;

endpackage

// File: rtl/bram_rd_pipe.sv
// Per-port read delay line: RD_LAT-1 stages after stage 0 plus the q register.
module bram_rd_pipe #(
    parameter int unsigned DWIDTH = 256,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic [DWIDTH-1:0] q,
    output logic              qvalid
);

    localparam int unsigned NSTG = RD_LAT - 1;

    logic [NSTG-1:0]   vld;
    logic [DWIDTH-1:0] dat [NSTG];

    // Valid bits and output register; q holds when no read completes
    always_ff @(posedge clock) begin
        if (reset) begin
            vld    <= '0;
            q      <= '0;
            qvalid <= 1'b0;
        end else begin
            vld[0] <= in_valid;
            for (int unsigned i = 1; i < NSTG; i++) begin
                vld[i] <= vld[i-1];
            end
            qvalid <= vld[NSTG-1];
            if (vld[NSTG-1]) begin
                q <= dat[NSTG-1];
            end
        end
    end

    // Data shift; qualified by the valid bits so no reset needed
    always_ff @(posedge clock) begin
        dat[0] <= in_data;
        for (int unsigned i = 1; i < NSTG; i++) begin
            dat[i] <= dat[i-1];
        end
    end

endmodule

// File: rtl/bram_true2port_v2.sv
// True dual-port RAM with byte lanes, registered requests, init sweep and
// write/write collision flag.
module bram_true2port_v2 import bram_pkg::*; #(
    parameter int unsigned      AWIDTH         = 12,
    parameter int unsigned      DWIDTH         = 256,
    parameter int unsigned      DEPTH          = 2048,
    parameter int unsigned      BWIDTH         = 8,
    parameter int unsigned      RD_LAT         = 2,
    parameter rdw_mode_t        RDW_MODE       = RDW_OLD,
    parameter bit               CLEAR_ON_RESET = 1'b1,
    parameter logic [DWIDTH-1:0] INIT_VAL      = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [AWIDTH-1:0]        address_a,
    input  logic [AWIDTH-1:0]        address_b,
    input  logic [DWIDTH-1:0]        data_a,
    input  logic [DWIDTH-1:0]        data_b,
    input  logic [DWIDTH/BWIDTH-1:0] byteen_a,
    input  logic [DWIDTH/BWIDTH-1:0] byteen_b,
    input  logic                     wren_a,
    input  logic                     wren_b,
    input  logic                     rden_a,
    input  logic                     rden_b,
    output logic [DWIDTH-1:0]        q_a,
    output logic [DWIDTH-1:0]        q_b,
    output logic                     qvalid_a,
    output logic                     qvalid_b,
    output logic                     ready,
    output logic                     collision
);

    localparam int unsigned NB = DWIDTH / BWIDTH;
    localparam int unsigned CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Elaboration-time parameter legality
    if (DWIDTH % BWIDTH != 0) begin : g_bad_bwidth
        $error("bram_true2port_v2: DWIDTH must be a multiple of BWIDTH");
    end
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("bram_true2port_v2: RD_LAT out of range");
    end
    if (DEPTH > (64'd1 << AWIDTH)) begin : g_bad_depth
        $error("bram_true2port_v2: DEPTH exceeds address space");
    end

    logic [DWIDTH-1:0] mem [DEPTH];

    init_state_t       state;
    logic [CW-1:0]     cnt;

    logic [AWIDTH-1:0] addr_in [2];
    logic [DWIDTH-1:0] data_in [2];
    logic [NB-1:0]     be_in   [2];
    logic [1:0]        wr_in;
    logic [1:0]        rd_in;

    logic [AWIDTH-1:0] addr_s0 [2];
    logic [DWIDTH-1:0] data_s0 [2];
    logic [NB-1:0]     be_s0   [2];
    logic [1:0]        wr_s0;
    logic [1:0]        rd_s0;

    logic [CW-1:0]     idx     [2];
    logic [1:0]        in_rng;
    logic [DWIDTH-1:0] rd_word [2];
    logic              coll_s1;

    assign addr_in[0] = address_a;
    assign addr_in[1] = address_b;
    assign data_in[0] = data_a;
    assign data_in[1] = data_b;
    assign be_in[0]   = byteen_a;
    assign be_in[1]   = byteen_b;
    assign wr_in      = {wren_b, wren_a};
    assign rd_in      = {rden_b, rden_a};

    // Init sweep FSM; ready is raised once the last word has been cleared
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (!CLEAR_ON_RESET || cnt == CW'(DEPTH - 1)) begin
                        state <= READY;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                READY:   ready <= 1'b1;
                default: state <= INIT;
            endcase
        end
    end

    // Stage 0: register every request; requests are dropped until ready
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_s0 <= '0;
            rd_s0 <= '0;
            for (int p = 0; p < 2; p++) begin
                addr_s0[p] <= '0;
                data_s0[p] <= '0;
                be_s0[p]   <= '0;
            end
        end else begin
            wr_s0 <= wr_in & {2{ready}};
            rd_s0 <= rd_in & {2{ready}};
            for (int p = 0; p < 2; p++) begin
                addr_s0[p] <= addr_in[p];
                data_s0[p] <= data_in[p];
                be_s0[p]   <= be_in[p];
            end
        end
    end

    // Address decode and read word; same-port merge only under RDW_NEW
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            idx[p]     = addr_s0[p][CW-1:0];
            in_rng[p]  = 32'(addr_s0[p]) < DEPTH;
            rd_word[p] = '0;
            if (in_rng[p]) begin
                rd_word[p] = mem[idx[p]];
                if (RDW_MODE == RDW_NEW && wr_s0[p]) begin
                    for (int unsigned l = 0; l < NB; l++) begin
                        if (be_s0[p][l]) begin
                            rd_word[p][l*BWIDTH +: BWIDTH] = data_s0[p][l*BWIDTH +: BWIDTH];
                        end
                    end
                end
            end
        end
    end

    // Memory writes: sweep, or port A lanes then port B lanes so B wins overlaps
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == INIT) begin
                if (CLEAR_ON_RESET) begin
                    mem[cnt] <= INIT_VAL;
                end
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (wr_s0[p] && in_rng[p]) begin
                        for (int unsigned l = 0; l < NB; l++) begin
                            if (be_s0[p][l]) begin
                                mem[idx[p]][l*BWIDTH +: BWIDTH] <= data_s0[p][l*BWIDTH +: BWIDTH];
                            end
                        end
                    end
                end
            end
        end
    end

    // Write/write same-address flag, aligned one cycle after the memory access
    always_ff @(posedge clock) begin
        if (reset) begin
            coll_s1   <= 1'b0;
            collision <= 1'b0;
        end else begin
            coll_s1   <= wr_s0[0] & wr_s0[1] & (addr_s0[0] == addr_s0[1]);
            collision <= coll_s1;
        end
    end

    bram_rd_pipe #(.DWIDTH(DWIDTH), .RD_LAT(RD_LAT)) u_pipe_a (
        .clock    (clock),
        .reset    (reset),
        .in_valid (rd_s0[0]),
        .in_data  (rd_word[0]),
        .q        (q_a),
        .qvalid   (qvalid_a)
    );

    bram_rd_pipe #(.DWIDTH(DWIDTH), .RD_LAT(RD_LAT)) u_pipe_b (
        .clock    (clock),
        .reset    (reset),
        .in_valid (rd_s0[1]),
        .in_data  (rd_word[1]),
        .q        (q_b),
        .qvalid   (qvalid_b)
    );

endmodule

// File: tb/tb_bram_true2port_v2.sv
// Two instances (RD_LAT=3/RDW_NEW and RD_LAT=2/RDW_OLD) share one stimulus and
// are checked each cycle against a word-level model plus literal expectations.
module tb_bram_true2port_v2;
    import bram_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  address_a, address_b;
    logic [15:0] data_a, data_b;
    logic [1:0]  byteen_a, byteen_b;
    logic        wren_a, wren_b, rden_a, rden_b;

    logic [15:0] q_n_a, q_n_b, q_o_a, q_o_b;
    logic        qv_n_a, qv_n_b, qv_o_a, qv_o_b;
    logic        rdy_n, rdy_o, coll_n, coll_o;

    always #5 clk = ~clk;

    bram_true2port_v2 #(
        .AWIDTH(5), .DWIDTH(16), .DEPTH(16), .BWIDTH(8), .RD_LAT(3),
        .RDW_MODE(RDW_NEW), .CLEAR_ON_RESET(1'b1), .INIT_VAL(16'h00A5)
    ) u_new (
        .clock(clk), .reset(reset),
        .address_a(address_a), .address_b(address_b),
        .data_a(data_a), .data_b(data_b),
        .byteen_a(byteen_a), .byteen_b(byteen_b),
        .wren_a(wren_a), .wren_b(wren_b), .rden_a(rden_a), .rden_b(rden_b),
        .q_a(q_n_a), .q_b(q_n_b), .qvalid_a(qv_n_a), .qvalid_b(qv_n_b),
        .ready(rdy_n), .collision(coll_n)
    );

    bram_true2port_v2 #(
        .AWIDTH(5), .DWIDTH(16), .DEPTH(16), .BWIDTH(8), .RD_LAT(2),
        .RDW_MODE(RDW_OLD), .CLEAR_ON_RESET(1'b1), .INIT_VAL(16'h00A5)
    ) u_old (
        .clock(clk), .reset(reset),
        .address_a(address_a), .address_b(address_b),
        .data_a(data_a), .data_b(data_b),
        .byteen_a(byteen_a), .byteen_b(byteen_b),
        .wren_a(wren_a), .wren_b(wren_b), .rden_a(rden_a), .rden_b(rden_b),
        .q_a(q_o_a), .q_b(q_o_b), .qvalid_a(qv_o_a), .qvalid_b(qv_o_b),
        .ready(rdy_o), .collision(coll_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d] t=%0t got=%0h want=%0h", nm, idx, $time, act, exp);
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = nw[7:0];
        if (be[1]) r[15:8] = nw[15:8];
        return r;
    endfunction

    // ---------------- model ----------------
    int          cyc = 0;
    int          rst_cyc = -1;
    bit          m_rdy = 1'b0;
    int          sweep = 16;
    logic [15:0] mm [16];
    int          pdue [4][$];
    logic [15:0] pdat [4][$];
    int          cdue [$];
    logic [4:0]  m_ad [2];
    logic [15:0] m_d  [2];
    logic [1:0]  m_be [2];
    logic [1:0]  m_wr, m_rd;
    logic [15:0] rv;

    // Word-level behaviour: reads see memory before this request's writes
    always @(posedge clk) begin
        cyc++;
        m_ad[0] = address_a; m_ad[1] = address_b;
        m_d[0]  = data_a;    m_d[1]  = data_b;
        m_be[0] = byteen_a;  m_be[1] = byteen_b;
        m_wr = {wren_b, wren_a};
        m_rd = {rden_b, rden_a};
        if (reset) begin
            for (int p = 0; p < 4; p++) begin pdue[p].delete(); pdat[p].delete(); end
            cdue.delete();
            m_rdy = 1'b0;
            sweep = 16;
            rst_cyc = cyc;
            for (int i = 0; i < 16; i++) mm[i] = 16'h00A5;
        end else if (!m_rdy) begin
            sweep--;
            if (sweep == 0) m_rdy = 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < 2; p++) begin
                    if (m_rd[p]) begin
                        rv = 16'h0;
                        if (int'(m_ad[p]) < 16) begin
                            rv = mm[m_ad[p][3:0]];
                            if (k == 0 && m_wr[p]) rv = merge(rv, m_d[p], m_be[p]);
                        end
                        pdue[k*2+p].push_back(cyc + ((k == 0) ? 3 : 2));
                        pdat[k*2+p].push_back(rv);
                    end
                end
            end
            if (m_wr[0] && m_wr[1] && m_ad[0] == m_ad[1]) cdue.push_back(cyc + 2);
            for (int p = 0; p < 2; p++) begin
                if (m_wr[p] && int'(m_ad[p]) < 16) mm[m_ad[p][3:0]] = merge(mm[m_ad[p][3:0]], m_d[p], m_be[p]);
            end
        end
    end

    // Per-cycle compare of every output against the model
    logic [15:0] qlast [4];
    logic [15:0] dq  [4];
    logic        dqv [4];
    bit          ev, ec;
    always @(negedge clk) begin
        if (cyc > 0) begin
            dq[0] = q_n_a; dq[1] = q_n_b; dq[2] = q_o_a; dq[3] = q_o_b;
            dqv[0] = qv_n_a; dqv[1] = qv_n_b; dqv[2] = qv_o_a; dqv[3] = qv_o_b;
            if (rst_cyc == cyc) for (int p = 0; p < 4; p++) qlast[p] = 16'h0;
            for (int p = 0; p < 4; p++) begin
                ev = pdue[p].size() > 0 && pdue[p][0] == cyc;
                if (ev) begin
                    qlast[p] = pdat[p][0];
                    void'(pdue[p].pop_front());
                    void'(pdat[p].pop_front());
                end
                check("qvalid", p, 32'(dqv[p]), 32'(ev));
                check("q", p, 32'(dq[p]), 32'(qlast[p]));
            end
            ec = cdue.size() > 0 && cdue[0] == cyc;
            if (ec) void'(cdue.pop_front());
            check("collision", 0, 32'(coll_n), 32'(ec));
            check("collision", 1, 32'(coll_o), 32'(ec));
            check("ready", 0, 32'(rdy_n), 32'(m_rdy));
            check("ready", 1, 32'(rdy_o), 32'(m_rdy));
        end
    end

    bit watch_b = 1'b0;
    bit seen_b  = 1'b0;
    always @(negedge clk) if (watch_b && (qv_n_b || qv_o_b)) seen_b = 1'b1;

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wren_a = 0; wren_b = 0; rden_a = 0; rden_b = 0;
        address_a = '0; address_b = '0; data_a = '0; data_b = '0;
        byteen_a = '0; byteen_b = '0;
    endtask

    task automatic set_a(input logic w, input logic r, input logic [4:0] a, input logic [15:0] d, input logic [1:0] be);
        wren_a = w; rden_a = r; address_a = a; data_a = d; byteen_a = be;
    endtask

    task automatic set_b(input logic w, input logic r, input logic [4:0] a, input logic [15:0] d, input logic [1:0] be);
        wren_b = w; rden_b = r; address_b = a; data_b = d; byteen_b = be;
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!rdy_n && n < 40) begin step(); n++; end
        check(nm, 0, 32'(n), 32'd16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        repeat (3) step();
        check("reset_ready", 0, 32'(rdy_n), 32'd0);
        check("reset_qv", 0, 32'(qv_n_a), 32'd0);
        reset = 1'b0;
        wait_ready("sweep_len");

        // whole memory reads back the clear pattern
        for (int a = 0; a < 16; a++) begin
            set_a(0, 1, 5'(a), 16'h0, 2'b00);
            set_b(0, 1, 5'(15 - a), 16'h0, 2'b00);
            step();
        end
        idle();
        repeat (4) step();

        // latency: write 1234 @5, then read @5
        set_a(1, 0, 5'd5, 16'h1234, 2'b11); step(); idle(); step();
        set_a(0, 1, 5'd5, 16'h0, 2'b00); step(); idle();
        step();
        check("lat_n1_qv", 0, 32'(qv_n_a), 32'd0);
        check("lat_o1_qv", 0, 32'(qv_o_a), 32'd0);
        step();
        check("lat_n2_qv", 0, 32'(qv_n_a), 32'd0);
        check("lat_o2_qv", 0, 32'(qv_o_a), 32'd1);
        check("lat_o2_q", 0, 32'(q_o_a), 32'h1234);
        step();
        check("lat_n3_qv", 0, 32'(qv_n_a), 32'd1);
        check("lat_n3_q", 0, 32'(q_n_a), 32'h1234);
        check("lat_o3_qv", 0, 32'(qv_o_a), 32'd0);
        step();
        check("lat_n4_qv", 0, 32'(qv_n_a), 32'd0);
        check("lat_n4_hold", 0, 32'(q_n_a), 32'h1234);

        // same-port read-during-write with a partial byte enable
        set_a(1, 0, 5'd3, 16'hFFFF, 2'b11); step(); idle(); step();
        set_a(1, 1, 5'd3, 16'h00AB, 2'b01); step(); idle();
        step(); step();
        check("rdw_old_q", 0, 32'(q_o_a), 32'hFFFF);
        step();
        check("rdw_new_q", 0, 32'(q_n_a), 32'hFFAB);
        set_b(0, 1, 5'd3, 16'h0, 2'b00); step(); idle(); repeat (4) step();

        // write/write on address 7: B wins, collision pulses
        set_a(1, 0, 5'd7, 16'h1111, 2'b11);
        set_b(1, 0, 5'd7, 16'h2222, 2'b11);
        step(); idle();
        step();
        check("coll_early", 0, 32'(coll_n), 32'd0);
        step();
        check("coll_pulse", 0, 32'(coll_n), 32'd1);
        check("coll_pulse", 1, 32'(coll_o), 32'd1);
        step();
        check("coll_once", 0, 32'(coll_n), 32'd0);
        set_a(0, 1, 5'd7, 16'h0, 2'b00); step(); idle(); repeat (3) step();
        check("ww_result", 0, 32'(q_n_a), 32'h2222);

        // partial overlap, zero byte enable, cross-port read vs write
        set_a(1, 0, 5'd8, 16'h1111, 2'b11);
        set_b(1, 0, 5'd8, 16'h2200, 2'b10);
        step(); idle();
        set_b(1, 0, 5'd10, 16'hFFFF, 2'b00); step(); idle();
        set_a(0, 1, 5'd9, 16'h0, 2'b00);
        set_b(1, 0, 5'd9, 16'h5A5A, 2'b11);
        step(); idle(); repeat (3) step();
        check("xport_old", 0, 32'(q_n_a), 32'h00A5);
        set_a(0, 1, 5'd8, 16'h0, 2'b00);
        set_b(0, 1, 5'd9, 16'h0, 2'b00);
        step(); idle(); repeat (3) step();
        check("lane_merge", 0, 32'(q_n_a), 32'h2211);

        // out-of-range address 20
        set_a(1, 0, 5'd20, 16'hBEEF, 2'b11); step(); idle();
        set_a(0, 1, 5'd20, 16'h0, 2'b00);
        set_b(0, 1, 5'd20, 16'h0, 2'b00);
        step(); idle(); repeat (3) step();
        check("oor_qv", 0, 32'(qv_n_a), 32'd1);
        check("oor_q", 0, 32'(q_n_a), 32'h0);
        for (int a = 0; a < 16; a++) begin
            set_a(0, 1, 5'(a), 16'h0, 2'b00);
            set_b(0, 1, 5'(a), 16'h0, 2'b00);
            step();
        end
        idle();
        repeat (4) step();

        // reset kills an in-flight B read; second reset lands mid-sweep
        set_b(0, 1, 5'd5, 16'h0, 2'b00); step(); idle();
        watch_b = 1'b1;
        reset = 1'b1; step(); step();
        reset = 1'b0;
        repeat (8) step();
        reset = 1'b1; step();
        reset = 1'b0;
        wait_ready("resweep_len");
        watch_b = 1'b0;
        check("inflight_dropped", 0, 32'(seen_b), 32'd0);
        set_a(0, 1, 5'd7, 16'h0, 2'b00);
        set_b(0, 1, 5'd5, 16'h0, 2'b00);
        step(); idle(); repeat (3) step();
        check("resweep_val", 0, 32'(q_n_a), 32'h00A5);
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
